// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and helpers
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_PASSB = 4'b0001;
  localparam logic [3:0] OP_NOT   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_ADC   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_OR    = 4'b1000;
  localparam logic [3:0] OP_DIV   = 4'b1001;
  localparam logic [3:0] OP_XOR   = 4'b1010;
  localparam logic [3:0] OP_SHL   = 4'b1011;
  localparam logic [3:0] OP_SHR   = 4'b1100;
  localparam logic [3:0] OP_RORC  = 4'b1101;
  localparam logic [3:0] OP_LAST  = OP_RORC;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  function automatic logic op_legal(
    input logic [3:0] ctl
  );
    return ctl <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: one write port with
// ALU-over-host priority, three async reads.
module alu_regfile #(
  parameter int NREGS = 4,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_we,
  input  logic [AW-1:0] alu_waddr,
  input  logic [3:0]    alu_wdata,
  input  logic          host_we,
  input  logic [AW-1:0] host_waddr,
  input  logic [3:0]    host_wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [3:0]    ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [3:0]    rb_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data
);

  logic [3:0] regs_q [NREGS];

  // Host and ALU may hit different entries in
  // the same cycle; only a collision yields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= 4'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (alu_we && alu_waddr == AW'(i))
          regs_q[i] <= alu_wdata;
        else if (host_we && host_waddr == AW'(i))
          regs_q[i] <= host_wdata;
      end
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign rd_data = regs_q[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU command at a time, waits for
// the result, writes it back and responds.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int NREGS   = 4,
  parameter int AW      = $clog2(NREGS),
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_ctl,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  input  logic [AW-1:0] cmd_dst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [3:0]    rd_data,
  output logic          alu_valid_in,
  output logic [3:0]    alu_a,
  output logic [3:0]    alu_b,
  output logic          alu_cin,
  output logic [3:0]    alu_ctl,
  input  logic          alu_valid_out,
  input  logic [3:0]    alu_res,
  input  logic          alu_carry,
  input  logic          alu_zero,
  output logic          rsp_valid,
  output logic [3:0]    rsp_data,
  output logic          rsp_err,
  output logic          carry_flag,
  output logic          zero_flag
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [3:0]    ctl_q;
  logic [AW-1:0] srca_q, srcb_q, dst_q;
  logic [3:0]    a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    rsp_data_q;
  logic          rsp_err_q;
  logic          carry_q, zero_q;
  logic [3:0]    rf_a, rf_b;

  logic st_idle, st_issue, st_wait, st_done;
  logic accept, wb, tmo;

  assign st_idle  = state_q == S_IDLE;
  assign st_issue = state_q == S_ISSUE;
  assign st_wait  = state_q == S_WAIT;
  assign st_done  = state_q == S_DONE;

  assign accept = cmd_valid && st_idle;
  assign wb     = st_wait && alu_valid_out;
  assign tmo    = st_wait && !alu_valid_out &&
                  cnt_q == CW'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (accept)
          state_d = op_legal(cmd_ctl) ?
                    S_ISSUE : S_DONE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:
        if (wb || tmo) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctl_q      <= 4'd0;
      srca_q     <= '0;
      srcb_q     <= '0;
      dst_q      <= '0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      cnt_q      <= '0;
      rsp_data_q <= 4'd0;
      rsp_err_q  <= 1'b0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctl_q  <= cmd_ctl;
        srca_q <= cmd_srca;
        srcb_q <= cmd_srcb;
        dst_q  <= cmd_dst;
        if (!op_legal(cmd_ctl)) begin
          rsp_err_q  <= 1'b1;
          rsp_data_q <= 4'd0;
        end
      end
      if (st_issue) begin
        a_q   <= rf_a;
        b_q   <= rf_b;
        cnt_q <= '0;
      end
      if (st_wait)
        cnt_q <= cnt_q + CW'(1);
      if (wb) begin
        carry_q    <= alu_carry;
        zero_q     <= alu_zero;
        rsp_data_q <= alu_res;
        rsp_err_q  <= 1'b0;
      end else if (tmo) begin
        rsp_data_q <= 4'd0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  alu_regfile #(
    .NREGS(NREGS),
    .AW   (AW)
  ) u_rf (
    .clk       (clk),
    .reset     (reset),
    .alu_we    (wb),
    .alu_waddr (dst_q),
    .alu_wdata (alu_res),
    .host_we   (wr_en),
    .host_waddr(wr_addr),
    .host_wdata(wr_data),
    .ra_addr   (srca_q),
    .ra_data   (rf_a),
    .rb_addr   (srcb_q),
    .rb_data   (rf_b),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Operands come live from the file in ISSUE,
  // then stay frozen while the ALU works.
  assign cmd_ready    = st_idle;
  assign alu_valid_in = st_issue;
  assign alu_a        = st_issue ? rf_a : a_q;
  assign alu_b        = st_issue ? rf_b : b_q;
  assign alu_cin      = carry_q;
  assign alu_ctl      = (st_issue || st_wait) ?
                        ctl_q : 4'd0;
  assign rsp_valid    = st_done;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign carry_flag   = carry_q;
  assign zero_flag    = zero_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side controller that drives the 4-bit ALU datapath. It owns a small operand register file and the carry/zero flag registers. It accepts one ALU command at a time over a valid/ready handshake and issues it to the ALU (a, b, cin, ctl, valid_in). It then waits for the ALU's valid_out, writes the result back to the register file, updates the flags and returns a one-cycle response.

Parameters:
NREGS, 4, number of 4-bit operand registers (power of 2, >=2)
AW, $clog2(NREGS), register address width
TIMEOUT, 8, max cycles spent in WAIT before an error response (>=3)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_ctl  input  4  ALU operation code
cmd_srca  input  AW  register index for port A
cmd_srcb  input  AW  register index for port B
cmd_dst  input  AW  destination register index
wr_en  input  1  host register write strobe
wr_addr  input  AW  host write index
wr_data  input  4  host write data
rd_addr  input  AW  debug read index
rd_data  output  4  combinational read of reg[rd_addr]
alu_valid_in  output  1  to ALU valid_in
alu_a  output  4  to ALU a
alu_b  output  4  to ALU b
alu_cin  output  1  to ALU cin (= carry_flag)
alu_ctl  output  4  to ALU ctl
alu_valid_out  input  1  from ALU valid_out
alu_res  input  4  from ALU result
alu_carry  input  1  from ALU carry
alu_zero  input  1  from ALU zero
rsp_valid  output  1  one-cycle response strobe
rsp_data  output  4  result written back (0 on error)
rsp_err  output  1  illegal ctl or timeout
carry_flag  output  1  carry flag register
zero_flag  output  1  zero flag register

Behaviour:
- Reset (async, reset=0): state=IDLE; all regs=0; carry_flag=0, zero_flag=0; rsp_valid=0, rsp_data=0, rsp_err=0; alu_valid_in=0, alu_ctl=0000, alu_a=0, alu_b=0; timeout counter=0. A reset mid-operation abandons the command with no writeback and no response.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready=1, alu_ctl=0000, alu_valid_in=0.
  - On cmd_valid at the clock edge, latch ctl/srca/srcb/dst.
  - Legal ctl (0000..1101): go to ISSUE.
  - Illegal ctl (1110, 1111): go to DONE with rsp_err=1, rsp_data=0, no ALU issue, no writeback, flags unchanged.
- ISSUE (exactly 1 cycle):
  - alu_valid_in=1; alu_a=reg[srca], alu_b=reg[srcb], alu_cin=carry_flag, alu_ctl=latched ctl.
  - Operands are sampled from the register file at the ISSUE cycle, after any host write in IDLE.
  - Next state WAIT; counter cleared.
- WAIT:
  - alu_valid_in=0; alu_ctl is held at the latched ctl, because the ALU's valid_out timing depends on ctl.
  - alu_a, alu_b and alu_cin are held.
  - Counter increments each cycle.
  - On alu_valid_out=1: reg[dst]<=alu_res, carry_flag<=alu_carry, zero_flag<=alu_zero, rsp_data<=alu_res, rsp_err<=0; go to DONE.
  - If the counter reaches TIMEOUT with no valid_out: rsp_err<=1, rsp_data<=0, no writeback; go to DONE.
- ALU response timing, all honoured by waiting on valid_out:
  - Normal ctl: valid_out is seen in the 1st WAIT cycle.
  - ctl=1001: seen in the 2nd WAIT cycle (1st WAIT cycle shows 0).
  - ctl=0110: seen in the 2nd WAIT cycle.
  - valid_out values present before WAIT are never sampled.
- DONE (exactly 1 cycle): rsp_valid=1, cmd_ready=0; next state IDLE.
- Latency, normal op: command accepted at edge E0 → ISSUE → WAIT → rsp_valid high in the 3rd cycle after E0. ctl 1001/0110 add one cycle.
- Host write:
  - wr_en writes reg[wr_addr] in any state.
  - If it hits the same address as the WAIT-state writeback in the same cycle, the ALU writeback wins.
  - A host write never touches the flags.
- rd_data reflects register contents combinationally (no write bypass).

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (OP_PASSA=0000 … OP_RORC=1101), OP_LAST=1101 for legality checks, and the FSM state enum.
- One sub-module: alu_regfile (NREGS x 4-bit, one write port with ALU-priority mux, two async read ports plus the debug read port).

Test Plan:
- reg0=3, reg1=5 via host; cmd ctl=0011 srca=0 srcb=1 dst=2 → alu_valid_in pulses 1 cycle with a=3, b=5; rsp_valid 3 cycles after accept; rsp_data=8, reg2=8, carry_flag=0, zero_flag=0.
- reg0=0xF, reg1=0x1, ctl=0011 dst=3 → rsp_data=0, carry_flag=1; next cmd ctl=0100 with a=1, b=1 → alu_cin=1, result 3.
- ctl=1001 and ctl=0110 → alu_ctl held through WAIT; rsp_valid 4 cycles after accept; correct writeback.
- cmd ctl=1110 → no alu_valid_in pulse; rsp_valid with rsp_err=1, rsp_data=0; registers and flags unchanged.
- ALU model holds alu_valid_out=0 → rsp_err=1 after TIMEOUT=8 WAIT cycles, no writeback; cmd_ready returns the following cycle.
- Assert reset while in WAIT → all outputs 0 immediately, state IDLE, no rsp_valid; same-cycle host write and ALU writeback to dst → ALU value stored.
